// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a 2**ADDR_WIDTH x DATA_WIDTH register file.
// SPI pins are oversampled in the clk domain; write commits are strobed to local logic.
module spi_slave_regs #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  reg_wr_vld,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  frame_err
);

  // state | meaning
  // IDLE  | waiting for a cs falling edge
  // CMD   | shifting in the R/W flag and address
  // WDATA | shifting in write data, commit on the last bit
  // RDATA | shifting register contents out on miso
  // DONE  | frame complete, extra sclk edges only counted

  localparam int NREG      = 1 << ADDR_WIDTH;
  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CMD_LEN   = 1 + ADDR_WIDTH;

  localparam logic [3:0] CNT_CMD   = 4'(CMD_LEN);
  localparam logic [3:0] CNT_FRAME = 4'(FRAME_LEN);
  localparam logic [3:0] CNT_MAX   = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    DONE
  } state_t;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [FRAME_LEN-2:0]   in_shift;
  logic [DATA_WIDTH-1:0]  rd_shift;
  logic [DATA_WIDTH-1:0]  regs [NREG];

  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [2:0] mosi_sync;

  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 cs_rise;
  logic                 cs_fall;
  logic                 mosi_bit;
  logic [FRAME_LEN-1:0] in_next;
  logic [3:0]           cnt_inc;
  logic                 cnt_bad;

  // Two synchroniser flops plus one history flop per pin; edges taken between stages 2 and 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs};
      mosi_sync <= {mosi_sync[1:0], mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  // mosi is stable for several clk around the sampling sclk edge, so the aligned stage is safe.
  assign mosi_bit  = mosi_sync[2];

  assign in_next = {in_shift, mosi_bit};
  assign cnt_inc = bit_cnt + 4'd1;
  assign cnt_bad = ((bit_cnt != 4'd0) && (bit_cnt < CNT_FRAME)) || (bit_cnt > CNT_FRAME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      in_shift    <= '0;
      rd_shift    <= '0;
      miso        <= 1'b0;
      reg_wr_vld  <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr_vld <= 1'b0;
      frame_err  <= 1'b0;

      // A cs rise outranks any sclk edge seen in the same cycle.
      if ((state != IDLE) && cs_rise) begin
        state <= IDLE;
        miso  <= 1'b0;
        if (cnt_bad) begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              bit_cnt  <= '0;
              in_shift <= '0;
              rd_shift <= '0;
              state    <= CMD;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              in_shift <= in_next[FRAME_LEN-2:0];
              bit_cnt  <= cnt_inc;
              if (cnt_inc == CNT_CMD) begin
                if (in_next[ADDR_WIDTH]) begin
                  state <= WDATA;
                end else begin
                  rd_shift <= regs[in_next[ADDR_WIDTH-1:0]];
                  state    <= RDATA;
                end
              end
            end
          end

          WDATA: begin
            if (sclk_rise) begin
              in_shift <= in_next[FRAME_LEN-2:0];
              bit_cnt  <= cnt_inc;
              if (cnt_inc == CNT_FRAME) begin
                if (in_next[FRAME_LEN-1]) begin
                  regs[in_next[DATA_WIDTH +: ADDR_WIDTH]] <= in_next[DATA_WIDTH-1:0];
                  reg_wr_addr <= in_next[DATA_WIDTH +: ADDR_WIDTH];
                  reg_wr_data <= in_next[DATA_WIDTH-1:0];
                  reg_wr_vld  <= 1'b1;
                end
                state <= DONE;
              end
            end
          end

          RDATA: begin
            if (sclk_rise) begin
              bit_cnt <= cnt_inc;
              if (cnt_inc == CNT_FRAME) begin
                state <= DONE;
              end
            end else if (sclk_fall) begin
              miso     <= rd_shift[DATA_WIDTH-1];
              rd_shift <= {rd_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end

          DONE: begin
            if (sclk_rise && (bit_cnt != CNT_MAX)) begin
              bit_cnt <= cnt_inc;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed plus randomized SPI frames against a register-array reference model.
module tb_spi_slave_regs;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       reg_wr_vld;
  logic [2:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_err;

  localparam int HALF = 5;

  int         vectors;
  int         miscompares;
  int         wr_pulses;
  int         err_pulses;
  logic [2:0] cap_addr;
  logic [7:0] cap_data;
  logic [7:0] model [8];

  spi_slave_regs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .reg_wr_vld  (reg_wr_vld),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_vld === 1'b1) begin
      wr_pulses++;
      cap_addr = reg_wr_addr;
      cap_data = reg_wr_data;
    end
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cs-low window with nclk sclk pulses; checks strobes, read data and idle miso.
  task automatic frame(input logic [11:0] word, input int nclk, input int gap);
    logic [7:0] rd;
    logic [7:0] want_rd;
    logic [2:0] a;
    logic       is_wr;
    int         exp_wr;
    int         exp_err;
    rd      = 8'h00;
    a       = word[10:8];
    is_wr   = word[11];
    want_rd = model[a];
    exp_wr  = (is_wr && nclk >= 12) ? 1 : 0;
    exp_err = ((nclk >= 1 && nclk <= 11) || nclk > 12) ? 1 : 0;
    @(negedge clk);
    wr_pulses  = 0;
    err_pulses = 0;
    cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      mosi = (k <= 12) ? word[12-k] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (k >= 5 && k <= 12) rd = {rd[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (gap) @(negedge clk);
    if (exp_wr == 1) model[a] = word[7:0];
    chk("wr_pulses", wr_pulses, exp_wr);
    chk("err_pulses", err_pulses, exp_err);
    chk("miso_idle", miso, 0);
    if (exp_wr == 1) begin
      chk("wr_addr", cap_addr, a);
      chk("wr_data", cap_data, word[7:0]);
    end
    if (!is_wr && nclk >= 12) chk("rd_data", rd, want_rd);
  endtask

  initial begin
    int         nclk_tab [10];
    logic [11:0] w;
    vectors     = 0;
    miscompares = 0;
    wr_pulses   = 0;
    err_pulses  = 0;
    nclk_tab    = '{0, 4, 7, 11, 12, 12, 12, 12, 13, 15};
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_wr_vld", reg_wr_vld, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_wr_addr", reg_wr_addr, 0);
    chk("rst_wr_data", reg_wr_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) frame({1'b0, 3'(i), 8'h00}, 12, 6);

    frame(12'hB5A, 12, 6);
    frame(12'h3A5, 12, 6);

    frame(12'hBFF, 7, 6);
    frame(12'h300, 12, 6);

    frame(12'hF81, 15, 6);
    frame(12'h700, 12, 6);

    for (int i = 0; i < 8; i++) frame({1'b1, 3'(i), 8'(8'h10 + i)}, 12, 5);
    for (int i = 0; i < 8; i++) frame({1'b0, 3'(i), 8'h00}, 12, 5);

    frame(12'h500, 0, 6);

    // Reset in the middle of a write frame with cs held low.
    @(negedge clk);
    wr_pulses  = 0;
    err_pulses = 0;
    w = 12'hA33;
    cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (k == 7) begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("midrst_miso", miso, 0);
        chk("midrst_wr_addr", reg_wr_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
      end
      mosi = w[12-k];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_wr_pulses", wr_pulses, 0);
    chk("midrst_err_pulses", err_pulses, 0);
    frame(12'h200, 12, 6);
    frame(12'hA33, 12, 6);
    frame(12'h2FF, 12, 6);

    for (int n = 0; n < 40; n++) begin
      w = 12'($urandom);
      frame(w, nclk_tab[$urandom_range(0, 9)], 5 + $urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) frame({1'b0, 3'(i), 8'(i * 37)}, 12, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 responder and 8-entry register file; it is the far end of the team's 12-bit SPI command master. It decodes write frames into register updates and answers read frames by shifting register contents out on miso. The SPI pins are oversampled in the system clock domain, and every write commit is reported on a one-cycle strobe to local logic.

## Interface
- ADDR_WIDTH, 3, register address bits; the block holds 2**ADDR_WIDTH registers.
- DATA_WIDTH, 8, register width in bits.
- Command frame length is fixed at 1+ADDR_WIDTH+DATA_WIDTH, which is 12 at the defaults.

- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sclk  input  1  SPI clock from the master; idles low; asynchronous to clk.
- cs  input  1  chip select, active-low, asynchronous.
- mosi  input  1  serial data from the master, MSB first.
- miso  output  1  serial read data to the master, MSB first; 0 whenever not shifting read data.
- reg_wr_vld  output  1  one-cycle pulse when a write frame commits.
- reg_wr_addr  output  ADDR_WIDTH  address of the last committed write.
- reg_wr_data  output  DATA_WIDTH  data of the last committed write.
- frame_err  output  1  one-cycle pulse when cs deasserts after a short frame or an overlong frame.

## Operation
- Input synchronisation:
  - sclk, cs and mosi each pass through 2 synchroniser flops plus 1 history flop.
  - Edges are detected between the 2nd and 3rd flop.
  - All sync flops reset to 0. As a result, cs held low through reset never produces a falling edge, so no frame starts.
- Frame layout, in mosi order:
  - bit 11: R/W flag (1 = write, 0 = read).
  - bits 10:8: address.
  - bits 7:0: write data (write frames only).
- The slave samples mosi on sclk rising edges. It updates miso on sclk falling edges (mode 0).
- State machine (4-bit bit_cnt counts sclk rising edges in the frame):
  - IDLE: waiting. A detected cs falling edge clears bit_cnt and the shift registers, then goes to CMD.
  - CMD: shift in mosi on each rising edge. On the 4th rising edge:
    - flag = 1 goes to WDATA.
    - flag = 0 loads rd_shift from regs[addr] and goes to RDATA.
  - WDATA: shift in mosi on rising edges 5..12. On the 12th rising edge, write regs[addr] and go to DONE.
  - RDATA: on each falling edge, miso takes rd_shift[MSB] and rd_shift shifts left.
    - The first such falling edge is the one after rising edge 4.
    - mosi is ignored.
    - Go to DONE on rising edge 12.
  - DONE: further sclk edges are ignored and counted (saturating at 15). miso holds its last value.
- cs rising edge, from any non-IDLE state, returns to IDLE and forces miso to 0.
  - frame_err pulses if bit_cnt is 1..11: the frame is aborted and no register changes.
  - frame_err pulses if bit_cnt > 12: overrun; a write already committed stays committed.
  - No pulse if bit_cnt is exactly 12, or 0 (cs toggled with no clocks).
- If cs rise and an sclk edge are detected in the same cycle, the cs rise wins and the sclk edge is discarded.
- Reset (at any time, including mid-frame):
  - State IDLE, bit_cnt 0, all registers 0.
  - miso, reg_wr_vld and frame_err are 0; reg_wr_addr and reg_wr_data are 0.
  - The next frame needs a fresh cs falling edge.

## Timing
- Requirements on the SPI side:
  - sclk high time and low time are each ≥ 4 clk periods.
  - cs falling edge to first sclk rising edge ≥ 4 clk.
  - Last sclk falling edge to cs rising edge ≥ 4 clk.
  - cs high time between frames ≥ 4 clk.
- Pin-to-action latency is 3 clk: a pin edge at clk n is acted on at clk n+3.
- Write commit:
  - regs[addr], reg_wr_addr and reg_wr_data update on the clk edge that acts on sclk rising edge 12.
  - reg_wr_vld is high for exactly that one following cycle.
- Read:
  - rd_shift loads 3 clk after sclk rising edge 4.
  - miso bit 7 is valid ≤ 4 clk after the following sclk falling edge, which is before rising edge 5 given the 4-clk low time.
  - Bits 6..0 follow on successive falling edges.
- A read of the register being written in the same frame is impossible. A read frame directly after a write frame returns the new value.
- frame_err asserts 3 clk after the cs rising edge, for 1 cycle.

## Test plan
- Reset values: read frames to addr 0..7 after reset → miso yields 0x00 for each; no reg_wr_vld, no frame_err.
- Write then read: write frame 0xB5A (addr 3, data 0x5A) → reg_wr_vld one cycle, reg_wr_addr=3, reg_wr_data=0x5A. Then read frame 0x3xx → miso bits = 0x5A.
- Aborted write: write 0xB5A, then a frame 0xBFF with cs raised after 7 sclk → frame_err one pulse, no reg_wr_vld; a read of addr 3 still returns 0x5A.
- Overrun: write frame 0xF81 (addr 7, data 0x81) followed by 3 extra sclk → reg_wr_vld once after edge 12, frame_err at cs rise; read addr 7 = 0x81.
- Back-to-back: 8 writes (addr i, data 0x10+i) with minimum cs gap, then 8 reads → each returns 0x10+i; miso = 0 while cs is high.
- Reset mid-frame: assert rst_n low after 6 sclk of write 0xA33 with cs still low; release; continue clocking → no commit; read addr 2 = 0x00; the next proper frame works.
